// File: rtl/mbt_pkg.sv
// mbt_pkg: shared definitions for the Mandelbrot/Julia escape-time engine.
//   - state_t   : engine FSM encoding (IDLE, ITER, DONE)
//   - fx_one    : fixed-point 1.0 for a given number of fraction bits
//   - fx_four_sq: escape threshold 4.0 expressed at the scale of a squared
//                 magnitude (2*frac fraction bits), i.e. 4 << (2*frac)
package mbt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [63:0] fx_one(input int frac);
    return 64'd1 << frac;
  endfunction

  // |z|^2 carries 2*frac fraction bits, so 4.0 is 4 * ONE * ONE.
  function automatic logic [63:0] fx_four_sq(input int frac);
    return (fx_one(frac) * fx_one(frac)) << 2;
  endfunction

endpackage

// File: rtl/mbt_cplx_sq.sv
// mbt_cplx_sq: combinational complex step of the escape-time iteration.
//   Computes next z = z^2 + c and the squared magnitude of the current z.
//   Optional macro MBT_SAT_EN: saturate the W+2-bit sums to the W-bit range;
//   when undefined the sums wrap (low W bits kept).
// Ports:
//   z_re, z_im   in   W      current z (signed fixed point, FRAC fraction bits)
//   c_re, c_im   in   W      additive constant c
//   nz_re, nz_im out  W      z^2 + c reduced to W bits
//   mag2         out  2W+1   zr^2 + zi^2 at full precision (2*FRAC fraction bits)
module mbt_cplx_sq #(
  parameter int W    = 16,
  parameter int FRAC = 11
) (
  input  logic signed [W-1:0] z_re,
  input  logic signed [W-1:0] z_im,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  output logic signed [W-1:0] nz_re,
  output logic signed [W-1:0] nz_im,
  output logic        [2*W:0] mag2
);

`ifdef MBT_SAT_EN
  localparam logic signed [W+1:0] SUM_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SUM_MIN = {3'b111, {(W-1){1'b0}}};
`endif

  // Reduce a W+2-bit sum to W bits: clamp or wrap depending on build.
  function automatic logic signed [W-1:0] fit_w(input logic signed [W+1:0] s);
`ifdef MBT_SAT_EN
    if (s > SUM_MAX)
      fit_w = SUM_MAX[W-1:0];
    else if (s < SUM_MIN)
      fit_w = SUM_MIN[W-1:0];
    else
      fit_w = s[W-1:0];
`else
    fit_w = W'(s);
`endif
  endfunction

  logic signed [2*W-1:0] p_rr, p_ii, p_ri;
  logic signed [W+1:0]   t_rr, t_ii, t_ri, cr_x, ci_x;
  logic signed [W+1:0]   sum_re, sum_im;

  assign p_rr = z_re * z_re;
  assign p_ii = z_im * z_im;
  assign p_ri = z_re * z_im;

  // Squares are never negative, so zero-extension into 2W+1 bits is exact.
  assign mag2 = {1'b0, p_rr} + {1'b0, p_ii};

  // Rescale products back to FRAC fraction bits (truncating arithmetic shift),
  // then keep W+2 bits: enough headroom for the sum of three W-bit-range terms.
  assign t_rr = (W+2)'(p_rr >>> FRAC);
  assign t_ii = (W+2)'(p_ii >>> FRAC);
  assign t_ri = (W+2)'(p_ri >>> FRAC);
  assign cr_x = (W+2)'(c_re);
  assign ci_x = (W+2)'(c_im);

  assign sum_re = t_rr - t_ii + cr_x;
  assign sum_im = (t_ri <<< 1) + ci_x;

  assign nz_re = fit_w(sum_re);
  assign nz_im = fit_w(sum_im);

endmodule

// File: rtl/mbt_iter_engine.sv
// mbt_iter_engine: Mandelbrot/Julia escape-time engine, one iteration per clock.
//   Accepts a pixel coordinate over in_valid/in_ready, iterates z <= z^2 + c
//   until |z|^2 > 4 or the iteration cap is hit, and presents the result over
//   out_valid/out_ready. Optional macro MBT_SAT_EN selects saturating update
//   sums (see mbt_cplx_sq); default build wraps.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       pixel request handshake
//   in_re, in_im    [W]     pixel coordinate
//   julia                   0: Mandelbrot (z0=0, c=pixel), 1: Julia (z0=pixel, c=jc)
//   jc_re, jc_im    [W]     Julia constant
//   max_iter        [ITER_W] iteration cap
//   out_valid/out_ready     result handshake
//   out_count       [ITER_W] z updates applied before escape or cap
//   out_in_set              1 when the cap was reached without escape
//   out_zr, out_zi  [W]     final z
module mbt_iter_engine
  import mbt_pkg::*;
#(
  parameter int W      = 16,
  parameter int FRAC   = 11,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_re,
  input  logic [W-1:0]      in_im,
  input  logic              julia,
  input  logic [W-1:0]      jc_re,
  input  logic [W-1:0]      jc_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_count,
  output logic              out_in_set,
  output logic [W-1:0]      out_zr,
  output logic [W-1:0]      out_zi
);

  localparam logic [2*W:0] FOUR_SQ = (2*W+1)'(fx_four_sq(FRAC));

  state_t state, state_nx;

  logic signed [W-1:0] z_re, z_im, c_re, c_im;
  logic signed [W-1:0] nz_re, nz_im;
  logic [2*W:0]        mag2;
  logic [ITER_W-1:0]   cnt, max_q;
  logic                in_set_q;
  logic                accept, escape, capped;

  mbt_cplx_sq #(.W(W), .FRAC(FRAC)) u_sq (
    .z_re  (z_re),
    .z_im  (z_im),
    .c_re  (c_re),
    .c_im  (c_im),
    .nz_re (nz_re),
    .nz_im (nz_im),
    .mag2  (mag2)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // Escape is judged on the current z, and takes priority over the cap.
  assign escape    = (mag2 > FOUR_SQ);
  assign capped    = (cnt == max_q);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ITER;
      ITER:    if (escape || capped) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      z_re     <= '0;
      z_im     <= '0;
      c_re     <= '0;
      c_im     <= '0;
      cnt      <= '0;
      max_q    <= '0;
      in_set_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            // Mode and Julia constant only matter here: they pick z0 and c.
            if (julia) begin
              z_re <= in_re;
              z_im <= in_im;
              c_re <= jc_re;
              c_im <= jc_im;
            end else begin
              z_re <= '0;
              z_im <= '0;
              c_re <= in_re;
              c_im <= in_im;
            end
            cnt      <= '0;
            max_q    <= max_iter;
            in_set_q <= 1'b0;
          end
        end
        ITER: begin
          if (escape) begin
            in_set_q <= 1'b0;
          end else if (capped) begin
            in_set_q <= 1'b1;
          end else begin
            z_re <= nz_re;
            z_im <= nz_im;
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_count  = cnt;
  assign out_in_set = in_set_q;
  assign out_zr     = z_re;
  assign out_zi     = z_im;

endmodule

// File: tb/tb_mbt_iter_engine.sv
// tb_mbt_iter_engine: randomized + directed bench for mbt_iter_engine with a
// behavioural escape-time model computed in plain integer arithmetic.
module tb_mbt_iter_engine;

  localparam int W      = 16;
  localparam int FRAC   = 11;
  localparam int ITER_W = 8;
  localparam longint FOUR = longint'(4) << (2*FRAC);
  localparam longint M2   = longint'(1) << (W+2);
  localparam longint MW   = longint'(1) << W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_re, in_im, jc_re, jc_im;
  logic              julia;
  logic [ITER_W-1:0] max_iter;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_count;
  logic              out_in_set;
  logic [W-1:0]      out_zr, out_zi;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0]      got_zr;
  logic [ITER_W-1:0] got_cnt;
  logic              got_set;

  always #5 clk = ~clk;

  mbt_iter_engine #(.W(W), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .julia      (julia),
    .jc_re      (jc_re),
    .jc_im      (jc_im),
    .max_iter   (max_iter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_in_set (out_in_set),
    .out_zr     (out_zr),
    .out_zi     (out_zi)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Signed wrap of an integer into n bits (modulus m).
  function automatic longint wrap_m(input longint x, input longint m);
    longint r;
    r = x & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  // W+2-bit sum reduced to W bits.
  function automatic longint fit(input longint x);
    longint s;
    s = wrap_m(x, M2);
`ifdef MBT_SAT_EN
    if (s > MW / 2 - 1) return MW / 2 - 1;
    if (s < -(MW / 2))  return -(MW / 2);
    return s;
`else
    return wrap_m(s, MW);
`endif
  endfunction

  // Escape-time reference: iterate the complex map on integers.
  function automatic void ref_model(input bit jul, input longint pr, input longint pi,
                                    input longint jr, input longint ji, input int mi,
                                    output int n, output bit ins,
                                    output longint zr, output longint zi);
    longint cr, ci, a, b;
    if (jul) begin zr = pr; zi = pi; cr = jr; ci = ji; end
    else     begin zr = 0;  zi = 0;  cr = pr; ci = pi; end
    n = 0;
    ins = 0;
    for (int k = 0; k <= 300; k++) begin
      if (zr * zr + zi * zi > FOUR) begin ins = 0; break; end
      if (n == mi) begin ins = 1; break; end
      a = fit(((zr * zr) >>> FRAC) - ((zi * zi) >>> FRAC) + cr);
      b = fit(2 * ((zr * zi) >>> FRAC) + ci);
      zr = a;
      zi = b;
      n++;
    end
  endfunction

  task automatic run_px(input string tag, input bit jul, input logic [W-1:0] pr,
                        input logic [W-1:0] pi, input logic [W-1:0] jr,
                        input logic [W-1:0] ji, input logic [ITER_W-1:0] mi,
                        input int hold);
    int           e_cnt;
    bit           e_set;
    longint       e_zr, e_zi;
    logic [W-1:0] ezr, ezi;
    int           cyc;
    ref_model(jul, longint'($signed(pr)), longint'($signed(pi)),
              longint'($signed(jr)), longint'($signed(ji)), int'(mi),
              e_cnt, e_set, e_zr, e_zi);
    ezr = e_zr[W-1:0];
    ezi = e_zi[W-1:0];
    @(negedge clk);
    in_valid = 1'b1; julia = jul; in_re = pr; in_im = pi;
    jc_re = jr; jc_im = ji; max_iter = mi;
    @(posedge clk);
    #1;
    // Scramble the inputs: they must have been captured at acceptance.
    in_valid = 1'b0; julia = ~jul; jc_re = W'($urandom); jc_im = W'($urandom);
    max_iter = ITER_W'($urandom); in_re = W'($urandom); in_im = W'($urandom);
    @(negedge clk);
    cyc = 0;
    while (!out_valid && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, cyc, e_cnt + 1);
    chk({tag, "_count"}, out_count, e_cnt);
    chk({tag, "_in_set"}, out_in_set, e_set);
    chk({tag, "_zr"}, out_zr, ezr);
    chk({tag, "_zi"}, out_zi, ezi);
    got_zr  = out_zr;
    got_cnt = out_count;
    got_set = out_in_set;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_state"}, {out_valid, in_ready}, 2'b10);
      chk({tag, "_hold_data"}, {out_count, out_in_set, out_zr, out_zi},
          {got_cnt, got_set, ezr, ezi});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; julia = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0; jc_re = '0; jc_im = '0; max_iter = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {in_ready, out_valid}, 2'b10);
    chk("rst_data", {out_count, out_in_set, out_zr, out_zi}, 0);
    rst_n = 1'b1;

    // Directed cases
    run_px("m_zero", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 8'd99, 0);
    chk("m_zero_const", {got_cnt, got_set}, {8'd99, 1'b1});
    run_px("m_one", 1'b0, 16'h0800, 16'h0000, 16'h0, 16'h0, 8'd99, 0);
    chk("m_one_const", {got_cnt, got_set, got_zr}, {8'd3, 1'b0, 16'h2800});
    run_px("m_two", 1'b0, 16'h1000, 16'h0000, 16'h0, 16'h0, 8'd99, 0);
    chk("m_two_const", {got_cnt, got_zr}, {8'd2, 16'h3000});
    run_px("m_neg2", 1'b0, 16'hF000, 16'h0000, 16'h0, 16'h0, 8'd50, 0);
    chk("m_neg2_const", {got_cnt, got_set, got_zr}, {8'd50, 1'b1, 16'h1000});
    run_px("j_1p5", 1'b1, 16'h0C00, 16'h0000, 16'h0, 16'h0, 8'd10, 0);
    chk("j_1p5_const", {got_cnt, got_zr}, {8'd1, 16'h1200});
    run_px("j_half", 1'b1, 16'h0400, 16'h0000, 16'h0, 16'h0, 8'd20, 0);
    chk("j_half_const", got_set, 1'b1);
    run_px("j_cap0", 1'b1, 16'h0400, 16'h0200, 16'h0, 16'h0, 8'd0, 0);
    chk("j_cap0_const", {got_cnt, got_set}, {8'd0, 1'b1});
    run_px("j_esc0", 1'b1, 16'h1800, 16'h0000, 16'h0, 16'h0, 8'd0, 0);
    chk("j_esc0_const", {got_cnt, got_set}, {8'd0, 1'b0});
    run_px("j_ovf", 1'b1, 16'h0F33, 16'h0000, 16'h7800, 16'h0, 8'd10, 0);
    chk("j_ovf_count", got_cnt, 8'd1);
`ifdef MBT_SAT_EN
    chk("j_ovf_sat", got_zr, 16'h7FFF);
`else
    chk("j_ovf_wrap_sign", got_zr[W-1], 1'b1);
`endif

    // Backpressure: result must hold while out_ready is low
    run_px("bp", 1'b0, 16'hFC00, 16'h0600, 16'h0, 16'h0, 8'd30, 10);

    // Randomized pixels
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] pr, pi, jr, ji;
      pr = W'(longint'($urandom_range(0, 10240)) - 5120);
      pi = W'(longint'($urandom_range(0, 10240)) - 5120);
      jr = W'(longint'($urandom_range(0, 4096)) - 2048);
      ji = W'(longint'($urandom_range(0, 4096)) - 2048);
      run_px("rnd", 1'($urandom_range(0, 1)), pr, pi, jr, ji,
             ITER_W'($urandom_range(0, 40)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an iteration aborts the pixel
    @(negedge clk);
    in_valid = 1'b1; julia = 1'b0; in_re = 16'h0100; in_im = 16'h0100; max_iter = 8'd99;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_async", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ctrl", {out_valid, in_ready}, 2'b01);
    chk("abort_data", {out_count, out_zr, out_zi}, 0);
    seen = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_stale", seen, 1'b0);
    run_px("post_rst", 1'b0, 16'h0800, 16'h0000, 16'h0, 16'h0, 8'd99, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
